// File: rtl/rot_tile_gen2.sv
// Rotatable/reflectable logic tile, WIDTH lanes per edge.
// Scan-loaded shadow config, atomic apply, selectable gate, optional loop breaker.
module rot_tile_gen2 #(
  parameter int WIDTH = 2,
  parameter int LB_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_se,
  input  logic             in_sc,
  input  logic             in_apply,
  input  logic             in_lb,
  input  logic [WIDTH-1:0] in_t,
  input  logic [WIDTH-1:0] in_r,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_l,
  output logic             out_sc,
  output logic [WIDTH-1:0] out_t,
  output logic [WIDTH-1:0] out_r,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_l,
  output logic [4:0]       cfg
);

  logic [WIDTH-1:0] r_st;
  logic [4:0]       r_sh;
  logic [4:0]       r_act;

  logic             w_v;
  logic             w_h;
  logic             w_d;
  logic [1:0]       w_f;
  logic [WIDTH-1:0] w_vt;
  logic [WIDTH-1:0] w_vb;
  logic [WIDTH-1:0] w_hr;
  logic [WIDTH-1:0] w_hl;
  logic [WIDTH-1:0] w_dh;
  logic [WIDTH-1:0] w_dv;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_gs;
  logic [WIDTH-1:0] w_hs;
  logic [WIDTH-1:0] w_oh;
  logic [WIDTH-1:0] w_ov;

  assign {w_v, w_h, w_d, w_f} = r_act;

  assign w_vt = w_v ? in_b : in_t;
  assign w_vb = w_v ? in_t : in_b;
  assign w_hr = w_h ? in_l : in_r;
  assign w_hl = w_h ? in_r : in_l;
  assign w_dh = w_d ? w_vt : w_hl;
  assign w_dv = w_d ? w_hl : w_vt;

  always_comb begin
    w_g = '0;
    unique case (w_f)
      2'b00: w_g = ~(w_hr & w_vb);
      2'b01: w_g = ~(w_hr | w_vb);
      2'b10: w_g = w_hr ^ w_vb;
      2'b11: w_g = ~(w_hr ^ w_vb);
    endcase
  end

  // Chain runs in_sc -> st[0..W-1] -> sh[0..4]; apply samples pre-edge sh.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st  <= '0;
      r_sh  <= '0;
      r_act <= '0;
    end else begin
      if (in_apply) r_act <= r_sh;
      if (in_se) begin
        {r_sh, r_st} <= {r_sh[3:0], r_st, in_sc};
      end else begin
        r_st <= w_dv;
      end
    end
  end

  generate
    if (LB_EN != 0) begin : g_lb
      logic [WIDTH-1:0] r_hg;
      logic [WIDTH-1:0] r_hh;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_hg <= '0;
          r_hh <= '0;
        end else if (!in_lb) begin
          r_hg <= w_g;
          r_hh <= w_dh;
        end
      end

      assign w_gs = in_lb ? r_hg : w_g;
      assign w_hs = in_lb ? r_hh : w_dh;
    end else begin : g_nolb
      logic w_unused_lb;
      assign w_unused_lb = in_lb;
      assign w_gs = w_g;
      assign w_hs = w_dh;
    end
  endgenerate

  assign w_oh = w_d ? w_gs : r_st;
  assign w_ov = w_d ? r_st : w_gs;

  assign out_t  = w_v ? w_hs : w_ov;
  assign out_b  = w_v ? w_ov : w_hs;
  assign out_r  = w_h ? w_oh : w_hs;
  assign out_l  = w_h ? w_hs : w_oh;
  assign out_sc = r_sh[4];
  assign cfg    = r_act;

endmodule
